key_expand_ctrl: RTL

KEY_EXPAND_CTRL -- requirements
Module: key_expand_ctrl

---
 rtl/key_expand_ctrl_pkg.sv | 35 +++
 rtl/key_expand_ctrl_key_schedule.sv | 29 ++
 rtl/key_expand_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/key_expand_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_expand_ctrl_pkg
// Brief    : Shared constants for the SIMON64/96 key-expansion block:
//            word size, key words, round count, round constant, z2 sequence
//            and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package key_expand_ctrl_pkg;

    localparam int WORD       = 32;
    localparam int M          = 3;
    localparam int NUM_ROUNDS = 42;
    localparam int IDX_W      = 6;
    localparam int Z_W        = 62;

    localparam logic [WORD-1:0] C  = 32'hfffffffc;
    // z2 sequence, consumed LSB first: bit j feeds round step j (key index j+3).
    localparam logic [Z_W-1:0]  Z2 = 62'h3369f885192c0ef5;

    localparam logic [IDX_W-1:0] FIRST_INDEX = IDX_W'(M);
    localparam logic [IDX_W-1:0] LAST_INDEX  = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] NUM_WORDS   = IDX_W'(NUM_ROUNDS);

    // Two-state controller encoding
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_EXPAND = 1'b1;

    // Rotate a key word right by a constant amount
    function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int n);
        return (x >> n) | (x << (WORD - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_expand_ctrl_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : keySchedule
// Brief    : Combinational SIMON64/96 (m=3) round step. Produces the next
//            round key from k[i-3], k[i-1] and the current z bit, and the
//            z register shifted right by one for the following step.
// Revision : 1.0 - initial release
// ============================================================================
module keySchedule
    import key_expand_ctrl_pkg::*;
(
    input  logic [WORD-1:0] i_kIm3,
    input  logic [WORD-1:0] i_kIm1,
    input  logic [Z_W-1:0]  i_z,
    output logic [WORD-1:0] o_roundKey,
    output logic [Z_W-1:0]  o_shiftZ
);

    logic [WORD-1:0] w_zWord;

    // Round key: C ^ z ^ k[i-3] ^ ror3(k[i-1]) ^ ror4(k[i-1]); z sequence advances one bit
    always_comb begin
        w_zWord    = {{(WORD-1){1'b0}}, i_z[0]};
        o_roundKey = C ^ w_zWord ^ i_kIm3 ^ rotr(i_kIm1, 3) ^ rotr(i_kIm1, 4);
        o_shiftZ   = {1'b0, i_z[Z_W-1:1]};
    end

endmodule
`default_nettype wire

// File: rtl/key_expand_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_expand_ctrl
// Brief    : Controller for SIMON64/96 key expansion. On start, captures the
//            96-bit master key and generates all 42 round keys, one per
//            cycle, into an internal register store with a registered read
//            port.
// Revision : 1.0 - initial release
// ============================================================================
module key_expand_ctrl
    import key_expand_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3*WORD-1:0]      keyIn,
    input  logic [IDX_W-1:0]       rkAddr,
    output logic [WORD-1:0]        rkData,
    output logic                   busy,
    output logic                   done,
    output logic                   keysValid
);

    logic [0:0]       r_state;
    logic [0:0]       w_nextState;
    logic [IDX_W-1:0] r_index;
    logic [Z_W-1:0]   r_z;
    logic [Z_W-1:0]   w_zShift;
    logic [WORD-1:0]  r_keyStore [0:NUM_ROUNDS-1];
    logic [WORD-1:0]  w_roundKey;
    logic [IDX_W-1:0] w_addrM3;
    logic [IDX_W-1:0] w_addrM1;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             r_done;
    logic             r_keysValid;
    logic [WORD-1:0]  r_rkData;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nextState;
    end

    // Next-state logic: leave EXPAND once the final key word is written
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (start)  w_nextState = ST_EXPAND;
            ST_EXPAND: if (w_last) w_nextState = ST_IDLE;
            default:               w_nextState = ST_IDLE;
        endcase
    end

    // Output/control decode; start is only honoured from IDLE
    always_comb begin
        w_load = (r_state == ST_IDLE) && start;
        w_step = (r_state == ST_EXPAND);
        w_last = w_step && (r_index == LAST_INDEX);
        busy   = w_step;
    end

    // Operand addresses, held in range when the index is not meaningful (IDLE)
    always_comb begin
        w_addrM3 = '0;
        w_addrM1 = '0;
        if (r_index >= FIRST_INDEX && r_index <= LAST_INDEX) begin
            w_addrM3 = r_index - FIRST_INDEX;
            w_addrM1 = r_index - IDX_W'(1);
        end
    end

    keySchedule u_keySchedule (
        .i_kIm3     (r_keyStore[w_addrM3]),
        .i_kIm1     (r_keyStore[w_addrM1]),
        .i_z        (r_z),
        .o_roundKey (w_roundKey),
        .o_shiftZ   (w_zShift)
    );

    // Key store: master key words on accept, one generated word per EXPAND cycle
    always_ff @(posedge clk) begin
        if (!rst && w_load) begin
            r_keyStore[0] <= keyIn[WORD-1:0];
            r_keyStore[1] <= keyIn[2*WORD-1:WORD];
            r_keyStore[2] <= keyIn[3*WORD-1:2*WORD];
        end else if (!rst && w_step) begin
            r_keyStore[r_index] <= w_roundKey;
        end
    end

    // Sequencing state: index, z sequence, done pulse and keysValid level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index     <= '0;
            r_z         <= '0;
            r_done      <= 1'b0;
            r_keysValid <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_index     <= FIRST_INDEX;
                r_z         <= Z2;
                r_keysValid <= 1'b0;
            end else if (w_step) begin
                r_index <= r_index + IDX_W'(1);
                r_z     <= w_zShift;
                if (w_last) r_keysValid <= 1'b1;
            end
        end
    end

    // Registered read port; addresses past the last word read as zero
    always_ff @(posedge clk) begin
        if (rst)                    r_rkData <= '0;
        else if (rkAddr < NUM_WORDS) r_rkData <= r_keyStore[rkAddr];
        else                        r_rkData <= '0;
    end

    assign rkData    = r_rkData;
    assign done      = r_done;
    assign keysValid = r_keysValid;

endmodule
`default_nettype wire
